e_mdu: RTL and testbench

Execute-stage multiply/divide unit of the P7 five-stage MIPS pipeline. Sits beside the ALU in E and owns the HI/LO register pair. It runs mult/multu/div/divu as fixed-latency multi-cycle operations and executes mthi/mtlo/mfhi/mflo. It drives the Start and Busy signals that the D-stage hazard unit uses to stall MDU-class instructions.

---
 rtl/e_mdu_pkg.sv | 39 +++
 rtl/e_mdu_calc.sv | 76 +++++++
 rtl/e_mdu.sv | 115 +++++++++++
 tb/tb_e_mdu.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings, FSM states, op classifiers.
// Build option: define E_MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops.
package e_mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for several cycles and raise Start.
    function automatic logic is_multi_op(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef E_MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Purely combinational datapath of the MDU: 64-bit {HI,LO} result and a divide-by-zero flag.
// Build option: E_MDU_MADD_EN adds the accumulate ops that fold in the current HI/LO.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o,
    output logic        div_zero_o
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic        [63:0] s_prod;
    logic        [63:0] u_prod;
    logic        [31:0] b_safe;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] s_quo;
    logic signed [31:0] s_rem;
    logic        [31:0] u_quo;
    logic        [31:0] u_rem;
    logic               b_zero;

    assign a_sx   = {{32{a_i[31]}}, a_i};
    assign b_sx   = {{32{b_i[31]}}, b_i};
    assign s_prod = a_sx * b_sx;
    assign u_prod = {32'd0, a_i} * {32'd0, b_i};

    // A zero divisor is swapped for 1 so the dividers never see it; the flag suppresses the commit.
    assign b_zero = (b_i == 32'd0);
    assign b_safe = b_zero ? 32'd1 : b_i;
    assign a_s    = a_i;
    assign b_s    = b_safe;
    assign s_quo  = a_s / b_s;
    assign s_rem  = a_s % b_s;
    assign u_quo  = a_i / b_safe;
    assign u_rem  = a_i % b_safe;

`ifdef E_MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_i, lo_i};
`else
    logic unused_hilo;
    assign unused_hilo = ^{hi_i, lo_i};
`endif

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        res_o      = 64'd0;
        div_zero_o = 1'b0;
        case (op_i)
            MDU_MULT:  res_o = s_prod;
            MDU_MULTU: res_o = u_prod;
            MDU_DIV: begin
                res_o      = {s_rem, s_quo};
                div_zero_o = b_zero;
            end
            MDU_DIVU: begin
                res_o      = {u_rem, u_quo};
                div_zero_o = b_zero;
            end
`ifdef E_MDU_MADD_EN
            MDU_MADD:  res_o = acc + s_prod;
            MDU_MADDU: res_o = acc + u_prod;
            MDU_MSUB:  res_o = acc - s_prod;
            MDU_MSUBU: res_o = acc - u_prod;
`endif
            default:   res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle ops with fixed latency, drives Start/Busy.
// Build option: E_MDU_MADD_EN enables the madd-class accumulate ops (taking MULT_CYCLES).
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      tmp_q, tmp_d;
    logic             dz_q, dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      calc_res;
    logic             calc_dz;

    e_mdu_calc u_calc (
        .op_i       (MDUOp),
        .a_i        (A),
        .b_i        (B),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .res_o      (calc_res),
        .div_zero_o (calc_dz)
    );

    assign Start = is_multi_op(MDUOp) && !Req;
    assign Busy  = (state_q == ST_RUN);
    assign HI    = hi_q;
    assign LO    = lo_q;

    always_comb begin
        case (MDUOp)
            MDU_MFHI: MDUOut = hi_q;
            MDU_MFLO: MDUOut = lo_q;
            default:  MDUOut = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmp_d   = tmp_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    tmp_d   = calc_res;
                    dz_d    = calc_dz;
                    cnt_d   = is_div_op(MDUOp) ? DIV_CNT : MULT_CNT;
                    state_d = ST_RUN;
                end else if (!Req && (MDUOp == MDU_MTHI)) begin
                    hi_d = A;
                end else if (!Req && (MDUOp == MDU_MTLO)) begin
                    lo_d = A;
                end
            end
            ST_RUN: begin
                // The op already retired past E, so Req no longer affects it; new ops are ignored here.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    if (!dz_q) begin
                        hi_d = tmp_q[63:32];
                        lo_d = tmp_q[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tmp_q   <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmp_q   <= tmp_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized ops against an arithmetic model.
// Build option: E_MDU_MADD_EN selects the madd-enabled expectations.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdu_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .MDUOp  (mdu_op),
        .A      (a_in),
        .B      (b_in),
        .Req    (req),
        .Start  (start),
        .Busy   (busy),
        .HI     (hi),
        .LO     (lo),
        .MDUOut (mdu_out)
    );

    always #5 clk = ~clk;

    // Behavioural reference: applies one accepted op to the HI/LO model with plain arithmetic.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        case (op)
            MDU_MULT:  {ref_hi, ref_lo} = sp;
            MDU_MULTU: {ref_hi, ref_lo} = up;
            MDU_DIV:   if (b != 0) begin ref_lo = sa / sb; ref_hi = sa % sb; end
            MDU_DIVU:  if (b != 0) begin ref_lo = a / b;   ref_hi = a % b;   end
            MDU_MTHI:  ref_hi = a;
            MDU_MTLO:  ref_lo = a;
`ifdef E_MDU_MADD_EN
            MDU_MADD:  {ref_hi, ref_lo} = {ref_hi, ref_lo} + sp;
            MDU_MADDU: {ref_hi, ref_lo} = {ref_hi, ref_lo} + up;
            MDU_MSUB:  {ref_hi, ref_lo} = {ref_hi, ref_lo} - sp;
            MDU_MSUBU: {ref_hi, ref_lo} = {ref_hi, ref_lo} - up;
`endif
            default: ;
        endcase
    endtask

    // Presents one op for a single cycle, then counts Busy cycles (bounded) until the unit is idle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, output int busy_cycles, output logic start_seen);
        @(negedge clk);
        mdu_op = op; a_in = a; b_in = b; req = rq;
        #1 start_seen = start;
        @(posedge clk); #1;
        mdu_op = MDU_NONE; req = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 64) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
    endtask

    function automatic int exp_cycles(input logic [3:0] op);
        case (op)
            MDU_DIV, MDU_DIVU: return DC;
            MDU_MULT, MDU_MULTU: return MC;
`ifdef E_MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return MC;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; mdu_op = MDU_NONE; a_in = '0; b_in = '0; req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %0b want 0", start); end
        n_checks++; if (mdu_out !== 32'd0) begin n_fail++; $display("FAIL reset_mduout got %h want 0", mdu_out); end
        @(negedge clk);
        reset = 1'b0;
        ref_hi = 32'd0; ref_lo = 32'd0;
    endtask

    task automatic run_and_check(input string name, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        int   bc;
        logic st;
        issue(op, a, b, 1'b0, bc, st);
        model_apply(op, a, b);
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL %s_start got %0b want 1", name, st); end
        n_checks++; if (bc != exp_cycles(op)) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, exp_cycles(op)); end
        n_checks++; if (hi !== ref_hi) begin n_fail++; $display("FAIL %s_hi got %h want %h", name, hi, ref_hi); end
        n_checks++; if (lo !== ref_lo) begin n_fail++; $display("FAIL %s_lo got %h want %h", name, lo, ref_lo); end
    endtask

    task automatic test_directed();
        int   bc;
        logic st;
        run_and_check("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL mult_const got %h%h want FFFFFFFFFFFFFFFA", hi, lo); end
        run_and_check("divu", MDU_DIVU, 32'd100, 32'd7);
        n_checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_const got %h/%h want 2/14", hi, lo); end
        run_and_check("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        n_checks++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL div_const got %h/%h want FFFFFFFF/FFFFFFFD", hi, lo); end
        issue(MDU_MTHI, 32'h11, 32'd0, 1'b0, bc, st); model_apply(MDU_MTHI, 32'h11, 32'd0);
        n_checks++; if (bc != 0 || hi !== 32'h11) begin n_fail++; $display("FAIL mthi got hi=%h busy=%0d want 11/0", hi, bc); end
        issue(MDU_MTLO, 32'h22, 32'd0, 1'b0, bc, st); model_apply(MDU_MTLO, 32'h22, 32'd0);
        n_checks++; if (bc != 0 || lo !== 32'h22) begin n_fail++; $display("FAIL mtlo got lo=%h busy=%0d want 22/0", lo, bc); end
        run_and_check("div0", MDU_DIV, 32'd55, 32'd0);
        n_checks++; if ({hi, lo} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL div0_const got %h/%h want 11/22", hi, lo); end
    endtask

    task automatic test_mfhi_mflo();
        @(negedge clk);
        mdu_op = MDU_MFHI; #1;
        n_checks++; if (mdu_out !== ref_hi) begin n_fail++; $display("FAIL mfhi got %h want %h", mdu_out, ref_hi); end
        mdu_op = MDU_MFLO; #1;
        n_checks++; if (mdu_out !== ref_lo) begin n_fail++; $display("FAIL mflo got %h want %h", mdu_out, ref_lo); end
        mdu_op = MDU_NONE; #1;
        n_checks++; if (mdu_out !== 32'd0) begin n_fail++; $display("FAIL mdu_none_out got %h want 0", mdu_out); end
    endtask

    task automatic test_req();
        int   bc;
        logic st;
        issue(MDU_MULT, 32'd9, 32'd9, 1'b1, bc, st);
        n_checks++; if (st !== 1'b0) begin n_fail++; $display("FAIL req_start got %0b want 0", st); end
        n_checks++; if (bc != 0) begin n_fail++; $display("FAIL req_busy got %0d want 0", bc); end
        n_checks++; if (hi !== ref_hi || lo !== ref_lo) begin n_fail++; $display("FAIL req_hilo got %h/%h want %h/%h", hi, lo, ref_hi, ref_lo); end
        issue(MDU_MTLO, 32'd5, 32'd0, 1'b1, bc, st);
        n_checks++; if (lo !== ref_lo) begin n_fail++; $display("FAIL req_mtlo got %h want %h", lo, ref_lo); end
        // Req raised after the op left E must not cancel it.
        @(negedge clk);
        mdu_op = MDU_MULTU; a_in = 32'd1000; b_in = 32'd3000; req = 1'b0;
        @(posedge clk); #1;
        mdu_op = MDU_NONE; req = 1'b1;
        bc = 0;
        while (busy && bc < 64) begin bc++; @(posedge clk); #1; end
        req = 1'b0;
        model_apply(MDU_MULTU, 32'd1000, 32'd3000);
        n_checks++; if (bc != MC) begin n_fail++; $display("FAIL req_run_busy got %0d want %0d", bc, MC); end
        n_checks++; if (lo !== ref_lo || hi !== ref_hi) begin n_fail++; $display("FAIL req_run_hilo got %h/%h want %h/%h", hi, lo, ref_hi, ref_lo); end
    endtask

    task automatic test_reset_mid_run();
        int idle_bad;
        @(negedge clk);
        mdu_op = MDU_MULTU; a_in = 32'hFFFF_FFFF; b_in = 32'd2;
        @(posedge clk); #1;
        mdu_op = MDU_NONE;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_run_pre_busy got %0b want 1", busy); end
        reset = 1'b1; #1;
        ref_hi = 32'd0; ref_lo = 32'd0;
        n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rst_run_now got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
        @(negedge clk);
        reset = 1'b0;
        idle_bad = 0;
        repeat (DC + 2) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) idle_bad++;
        end
        n_checks++; if (idle_bad != 0) begin n_fail++; $display("FAIL rst_run_no_commit got %0d bad cycles want 0", idle_bad); end
    endtask

    task automatic test_madd();
        int   bc;
        logic st;
        issue(MDU_MTHI, 32'd0, 32'd0, 1'b0, bc, st); model_apply(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, bc, st); model_apply(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
`ifdef E_MDU_MADD_EN
        run_and_check("maddu", MDU_MADDU, 32'd1, 32'd1);
        n_checks++; if ({hi, lo} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL maddu_const got %h/%h want 1/0", hi, lo); end
        run_and_check("msub", MDU_MSUB, 32'hFFFF_FFFD, 32'd7);
`else
        issue(MDU_MADDU, 32'd1, 32'd1, 1'b0, bc, st);
        n_checks++; if (st !== 1'b0 || bc != 0) begin n_fail++; $display("FAIL maddu_off got start=%0b busy=%0d want 0/0", st, bc); end
        n_checks++; if ({hi, lo} !== {32'd0, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL maddu_off_hilo got %h/%h want 0/FFFFFFFF", hi, lo); end
`endif
    endtask

    task automatic test_random();
        logic [3:0]  ops [4] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            op = ops[$urandom_range(0, 3)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (op == MDU_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            run_and_check("rand", op, a, b);
        end
    endtask

    // Consecutive ops with no gap: the next op is issued in the first idle cycle.
    task automatic test_back_to_back();
        run_and_check("b2b_mult", MDU_MULT, 32'h8000_0000, 32'h8000_0000);
        run_and_check("b2b_divu", MDU_DIVU, 32'hFFFF_FFFF, 32'd16);
        run_and_check("b2b_div",  MDU_DIV,  32'd7, 32'hFFFF_FFFE);
        test_mfhi_mflo();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mfhi_mflo();
        test_req();
        test_reset_mid_run();
        test_madd();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
